// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline.
// Contents:
//   RD_W       width of a destination-register index
//   rd_t       destination-register index type
//   rd_hazard  1 when one in-flight entry writes the queried register
package pipe_pkg;

  localparam int RD_W = 5;

  typedef logic [RD_W-1:0] rd_t;

  // Register x0 is hard-wired, so a write to it can never create a RAW hazard.
  function automatic logic rd_hazard(input logic valid, input logic wen,
                                     input rd_t rd, input rd_t rs);
    return valid && wen && (rs != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline stage: a main register and a skid register.
// The main register drives downstream. When downstream stalls while upstream
// transfers, the incoming word parks in the skid register. in_ready comes
// straight from a flop, so no combinational path runs from out_ready to in_ready.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   flush                    clear both valid bits on this edge
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main register)
//   skid_valid/skid_data     skid register contents, used by the hazard scoreboard
module elastic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             skid_valid,
  output logic [WIDTH-1:0] skid_data
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_main_free;

  assign w_in_xfer   = in_valid && !r_skid_valid;
  assign w_out_xfer  = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_out_xfer;

  // The valid bits form the only state that reset or flush must clear.
  // A valid skid blocks upstream, so the skid never refills in the same
  // cycle that it drains into main.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      r_main_valid <= r_skid_valid || w_in_xfer;
      r_skid_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
    end
  end

  // NOTE: the payload registers have no reset. The valid bits qualify them,
  // and leaving them unreset keeps the reset net off WIDTH*2 flops per stage.
  always_ff @(posedge clk) begin
    if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_data <= r_skid_data;
      end else if (w_in_xfer) begin
        r_main_data <= in_data;
      end
    end else if (w_in_xfer) begin
      r_skid_data <= in_data;
    end
  end

  assign in_ready   = !r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign skid_valid = r_skid_valid;
  assign skid_data  = r_skid_data;

endmodule

// File: rtl/elastic_pipe.sv
// Chain of DEPTH elastic stages carrying a WIDTH-bit payload under valid/ready.
// The module also provides a global flush, an in-flight destination-register
// scoreboard for RAW hazard detection, and an occupancy count.
// Optional build macro ELASTIC_PIPE_STATS_EN adds the stat_xfers and
// stat_stalls counters.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready/in_data    producer side
//   out_valid/out_ready/out_data consumer side
//   flush                        discard every in-flight entry
//   rs1, rs2                     hazard query registers
//   hazard_rs1, hazard_rs2       a valid in-flight entry writes rs1 / rs2
//   occupancy                    number of valid entries (main + skid, all stages)
//   stat_xfers, stat_stalls      (ELASTIC_PIPE_STATS_EN only) output transfers / stall cycles
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2,
  parameter int RD_LSB  = 0,
  parameter int WEN_BIT = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           flush,
  input  logic [RD_W-1:0]                rs1,
  input  logic [RD_W-1:0]                rs2,
  output logic                           hazard_rs1,
  output logic                           hazard_rs2,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [31:0]                    stat_xfers,
  output logic [31:0]                    stat_stalls
`endif
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  // Index g is the boundary in front of stage g. Index DEPTH is the output port.
  logic [DEPTH:0]   w_valid;
  logic [DEPTH:0]   w_ready;
  logic [WIDTH-1:0] w_data [DEPTH+1];
  logic [DEPTH-1:0] w_skid_valid;
  logic [WIDTH-1:0] w_skid_data [DEPTH];
  logic [DEPTH-1:0] w_hz1;
  logic [DEPTH-1:0] w_hz2;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign w_ready[DEPTH] = out_ready;
  assign in_ready       = w_ready[0];
  assign out_valid      = w_valid[DEPTH];
  assign out_data       = w_data[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (w_valid[g]),
      .in_ready   (w_ready[g]),
      .in_data    (w_data[g]),
      .out_valid  (w_valid[g+1]),
      .out_ready  (w_ready[g+1]),
      .out_data   (w_data[g+1]),
      .skid_valid (w_skid_valid[g]),
      .skid_data  (w_skid_data[g])
    );

    // Both registers of every stage take part in the hazard check. The word
    // on the input port is not yet in flight and is excluded.
    assign w_hz1[g] =
      rd_hazard(w_valid[g+1], w_data[g+1][WEN_BIT], w_data[g+1][RD_LSB +: RD_W], rs1) |
      rd_hazard(w_skid_valid[g], w_skid_data[g][WEN_BIT],
                w_skid_data[g][RD_LSB +: RD_W], rs1);
    assign w_hz2[g] =
      rd_hazard(w_valid[g+1], w_data[g+1][WEN_BIT], w_data[g+1][RD_LSB +: RD_W], rs2) |
      rd_hazard(w_skid_valid[g], w_skid_data[g][WEN_BIT],
                w_skid_data[g][RD_LSB +: RD_W], rs2);
  end

  assign hazard_rs1 = |w_hz1;
  assign hazard_rs2 = |w_hz2;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] r_occupancy;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // A word accepted in a flush cycle is dropped, so flush forces the count to zero.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occupancy <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
        2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  assign occupancy = r_occupancy;

`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0] r_stat_xfers;
  logic [31:0] r_stat_stalls;

  // The counters observe the output port only. Flush does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_xfers  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_out_xfer) begin
        r_stat_xfers <= r_stat_xfers + 32'd1;
      end
      if (out_valid && !out_ready) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_xfers  = r_stat_xfers;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
module tb_elastic_pipe;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rs2 = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             hazard_rs1;
  logic             hazard_rs2;
  logic [OCC_W-1:0] occupancy;
`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0]      stat_xfers;
  logic [31:0]      stat_stalls;
  int unsigned      exp_xfers = 0;
  int unsigned      exp_stalls = 0;
`endif

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LSB(0), .WEN_BIT(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush      (flush),
    .rs1        (rs1),
    .rs2        (rs2),
    .hazard_rs1 (hazard_rs1),
    .hazard_rs2 (hazard_rs2),
    .occupancy  (occupancy)
`ifdef ELASTIC_PIPE_STATS_EN
    ,
    .stat_xfers (stat_xfers),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Expected hazard: any queued (in-flight) entry with wen=1 and rd==rs, rs!=0.
  function automatic logic model_hz(input logic [4:0] rs);
    logic hit;
    hit = 1'b0;
    foreach (exp_q[k]) begin
      if (exp_q[k][5] && (exp_q[k][4:0] == rs) && (rs != 5'd0)) hit = 1'b1;
    end
    return hit;
  endfunction

  // One clock. At the negedge, compare outputs against the scoreboard and
  // update the scoreboard with this cycle's transfers. Return #1 after the posedge.
  task automatic cycle();
    logic [WIDTH-1:0] exp;
    @(negedge clk);
    if (!reset) begin
      checks++;
      if (occupancy !== OCC_W'(exp_q.size())) begin
        errors++;
        $display("FAIL occupancy: got %0d, expected %0d", occupancy, exp_q.size());
      end
      checks++;
      if (hazard_rs1 !== model_hz(rs1)) begin
        errors++;
        $display("FAIL hazard_rs1 (rs1=%0d): got %b, expected %b", rs1, hazard_rs1, model_hz(rs1));
      end
      checks++;
      if (hazard_rs2 !== model_hz(rs2)) begin
        errors++;
        $display("FAIL hazard_rs2 (rs2=%0d): got %b, expected %b", rs2, hazard_rs2, model_hz(rs2));
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got %h, expected no output", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL out_data: got %h, expected %h", out_data, exp);
          end
        end
`ifdef ELASTIC_PIPE_STATS_EN
        exp_xfers++;
`endif
      end
`ifdef ELASTIC_PIPE_STATS_EN
      if (out_valid === 1'b1 && !out_ready) exp_stalls++;
`endif
      if (flush) exp_q.delete();
      else if (in_valid && in_ready === 1'b1) exp_q.push_back(in_data);
    end else begin
      exp_q.delete();
`ifdef ELASTIC_PIPE_STATS_EN
      exp_xfers  = 0;
      exp_stalls = 0;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rs1 = 5'd5;
    rs2 = 5'd7;
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy); end
    checks++;
    if ({hazard_rs1, hazard_rs2} !== 2'b00) begin
      errors++; $display("FAIL reset_hazard: got %b%b, expected 00", hazard_rs1, hazard_rs2);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_data  = 32'h11 + i;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle %0d: got %b, expected 1", i, in_ready); end
      checks++;
      if (out_valid !== (i >= 2)) begin
        errors++; $display("FAIL stream_out_valid cycle %0d: got %b, expected %b", i, out_valid, (i >= 2));
      end else if (i >= 2) begin
        checks++;
        if (out_data !== 32'h11 + i - 2) begin
          errors++; $display("FAIL stream_latency cycle %0d: got %h, expected %h", i, out_data, 32'h11 + i - 2);
        end
      end
      cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted  = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h21 + accepted;
      if (in_ready) accepted++;
      cycle();
    end
    checks++;
    if (accepted !== 4) begin errors++; $display("FAIL bp_accepted: got %0d, expected 4", accepted); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
    checks++;
    if (occupancy !== OCC_W'(4)) begin errors++; $display("FAIL bp_occupancy: got %0d, expected 4", occupancy); end
    out_ready = 1'b1;
    in_data   = 32'h25;
    for (int i = 0; i < 20 && accepted < 5; i++) begin
      if (in_ready) accepted++;
      cycle();
    end
    checks++;
    if (accepted !== 5) begin errors++; $display("FAIL bp_fifth_word: got %0d accepted, expected 5", accepted); end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h31 + i;
      cycle();
    end
    flush     = 1'b1;
    in_data   = 32'h3F;
    out_ready = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== '0) begin errors++; $display("FAIL flush_occupancy: got %0d, expected 0", occupancy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, expected 1", in_ready); end
    for (int i = 0; i < 5; i++) cycle();
  endtask

  task automatic test_hazard();
    bit found;
    rs1       = 5'd5;
    rs2       = 5'd0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h25;
    checks++;
    if (hazard_rs1 !== 1'b0) begin errors++; $display("FAIL hz_input_port: got %b, expected 0", hazard_rs1); end
    cycle();
    in_data = 32'h20;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (hazard_rs1 !== 1'b1) begin errors++; $display("FAIL hz_rs1_set: got %b, expected 1", hazard_rs1); end
    checks++;
    if (hazard_rs2 !== 1'b0) begin errors++; $display("FAIL hz_rs2_zero: got %b, expected 0", hazard_rs2); end
    out_ready = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid && out_data == 32'h25) begin
        found = 1'b1;
        cycle();
        checks++;
        if (hazard_rs1 !== 1'b0) begin errors++; $display("FAIL hz_drain_fall: got %b, expected 0", hazard_rs1); end
      end else begin
        cycle();
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hz_drain_timeout: got no output, expected 00000025"); end
    flush = 1'b1;
    cycle();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h05;
    rs2       = 5'd5;
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({hazard_rs1, hazard_rs2} !== 2'b00) begin
      errors++; $display("FAIL hz_wen0: got %b%b, expected 00", hazard_rs1, hazard_rs2);
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'h41 + i;
      cycle();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (occupancy !== '0) begin errors++; $display("FAIL rmid_occupancy: got %0d, expected 0", occupancy); end
`ifdef ELASTIC_PIPE_STATS_EN
    checks++;
    if (stat_xfers !== 32'd0 || stat_stalls !== 32'd0) begin
      errors++; $display("FAIL rmid_stats: got %0d/%0d, expected 0/0", stat_xfers, stat_stalls);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_data   = {$urandom_range(0, 32'hFFFF), 8'h00, 2'b00, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending, expected 0", exp_q.size()); end
`ifdef ELASTIC_PIPE_STATS_EN
    checks++;
    if (stat_xfers !== exp_xfers) begin errors++; $display("FAIL stat_xfers: got %0d, expected %0d", stat_xfers, exp_xfers); end
    checks++;
    if (stat_stalls !== exp_stalls) begin errors++; $display("FAIL stat_stalls: got %0d, expected %0d", stat_stalls, exp_stalls); end
`endif
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
